// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared states, opcode/funct/ALU codes and datapath select encodings
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
    S_ALUWB, S_BRANCH, S_IMM_EX, S_JUMP, S_JAL, S_ILLEGAL, S_HALT
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_ADD = 6'h20, F_SUB = 6'h22,
                         F_AND = 6'h24, F_OR = 6'h25, F_NOR = 6'h27, F_SLT = 6'h2A;
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_SLL = 4'b1000,
                         ALU_SRL = 4'b1001, ALU_NOR = 4'b1100;
  localparam logic [1:0] SRCB_B = 2'd0, SRCB_4 = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM4 = 2'd3;
  localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2;
  localparam logic [1:0] M2R_ALU = 2'd0, M2R_MDR = 2'd1, M2R_PC = 2'd2;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: latched opcode/funct to ALU operation, flags unsupported R-type funct
module mips_alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 4
) (
  input  logic [5:0]           op_i,
  input  logic [5:0]           funct_i,
  output logic [ALUCTRL_W-1:0] alu_ctrl_o,
  output logic                 funct_illegal_o
);
  logic [3:0] r_code;
  logic       bad;
  always_comb begin
    r_code = ALU_ADD;
    bad = 1'b0;
    case (funct_i)
      F_ADD:   r_code = ALU_ADD;
      F_SUB:   r_code = ALU_SUB;
      F_AND:   r_code = ALU_AND;
      F_OR:    r_code = ALU_OR;
      F_NOR:   r_code = ALU_NOR;
      F_SLT:   r_code = ALU_SLT;
      F_SLL:   r_code = ALU_SLL;
      F_SRL:   r_code = ALU_SRL;
      default: bad = 1'b1;
    endcase
  end
  assign alu_ctrl_o = ALUCTRL_W'(op_i == OP_RTYPE ? r_code :
                                 op_i == OP_ANDI  ? ALU_AND :
                                 op_i == OP_ORI   ? ALU_OR  : ALU_ADD);
  assign funct_illegal_o = (op_i == OP_RTYPE) && bad;
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore FSM sequencing the shared multi-cycle MIPS datapath
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W       = 4,
  parameter int HAS_JAL         = 1,
  parameter int TRAP_ON_ILLEGAL = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           destination_indicator,
  output logic [1:0]           MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 ExtZero,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           PCSrc,
  output logic                 PCEn,
  output logic                 illegal_instr,
  output logic [3:0]           state_dbg
);
  state_e                 state_q, state_d;
  logic [5:0]             op_q, funct_q;
  logic [ALUCTRL_W-1:0]   dec_alu;
  logic                   funct_bad;

  mips_alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_dec (
    .op_i(op_q), .funct_i(funct_q), .alu_ctrl_o(dec_alu), .funct_illegal_o(funct_bad)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q    <= opcode;
        funct_q <= funct;
      end
    end
  end

  // Dispatch in DECODE reads the live IR fields; every output uses only the latched copies.
  always_comb begin
    state_d = state_q;
    IorD = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    destination_indicator = DST_RT;
    MemtoReg = M2R_ALU;
    RegWrite = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = SRCB_B;
    ExtZero = 1'b0;
    ALUControl = ALUCTRL_W'(ALU_ADD);
    PCSrc = PC_ALU;
    PCEn = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        ALUSrcB = SRCB_4;
        PCEn = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM4;
        case (opcode)
          OP_LW, OP_SW:              state_d = S_MEMADR;
          OP_RTYPE:                  state_d = S_EXEC_R;
          OP_BEQ, OP_BNE:            state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IMM_EX;
          OP_J:                      state_d = S_JUMP;
          OP_JAL:                    state_d = HAS_JAL != 0 ? S_JAL : S_ILLEGAL;
          default:                   state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = op_q == OP_SW ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_MDR;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        IorD = 1'b1;
        MemWrite = 1'b1;
        state_d = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUControl = dec_alu;
        state_d = funct_bad ? S_ILLEGAL : S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        destination_indicator = op_q == OP_RTYPE ? DST_RD : DST_RT;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUControl = ALUCTRL_W'(ALU_SUB);
        PCSrc = PC_ALUOUT;
        PCEn = (op_q == OP_BNE) ^ zero;
        state_d = S_FETCH;
      end
      S_IMM_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ExtZero = (op_q == OP_ANDI) || (op_q == OP_ORI);
        ALUControl = dec_alu;
        state_d = S_ALUWB;
      end
      S_JUMP: begin
        PCSrc = PC_JUMP;
        PCEn = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        RegWrite = 1'b1;
        destination_indicator = DST_RA;
        MemtoReg = M2R_PC;
        PCSrc = PC_JUMP;
        PCEn = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_instr = 1'b1;
        state_d = TRAP_ON_ILLEGAL != 0 ? S_HALT : S_FETCH;
      end
      S_HALT: illegal_instr = 1'b1;
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      IorD = 1'b0;
      MemWrite = 1'b0;
      IRWrite = 1'b0;
      destination_indicator = '0;
      MemtoReg = '0;
      RegWrite = 1'b0;
      ALUSrcA = 1'b0;
      ALUSrcB = '0;
      ExtZero = 1'b0;
      ALUControl = '0;
      PCSrc = '0;
      PCEn = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  assign state_dbg = state_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed checks of the default unit and a trapping, jal-less variant
module tb_mips_multicycle_control;
  logic clk = 1'b0;
  logic reset, zero;
  logic [5:0] opcode, funct;
  logic iord, mw, irw, rw, srca, extz, pcen, ill;
  logic [1:0] dst, m2r, srcb, pcsrc;
  logic [3:0] alu, st;
  logic t_iord, t_mw, t_irw, t_rw, t_srca, t_extz, t_pcen, t_ill;
  logic [1:0] t_dst, t_m2r, t_srcb, t_pcsrc;
  logic [4:0] t_alu;
  logic [3:0] t_st;
  int n_cmp = 0, n_err = 0;
  int mw_cnt, rw_cnt;

  always #5 clk = ~clk;

  mips_multicycle_control u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .IorD(iord), .MemWrite(mw), .IRWrite(irw), .destination_indicator(dst),
    .MemtoReg(m2r), .RegWrite(rw), .ALUSrcA(srca), .ALUSrcB(srcb), .ExtZero(extz),
    .ALUControl(alu), .PCSrc(pcsrc), .PCEn(pcen), .illegal_instr(ill), .state_dbg(st)
  );

  mips_multicycle_control #(.ALUCTRL_W(5), .HAS_JAL(0), .TRAP_ON_ILLEGAL(1)) u_trap (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .IorD(t_iord), .MemWrite(t_mw), .IRWrite(t_irw), .destination_indicator(t_dst),
    .MemtoReg(t_m2r), .RegWrite(t_rw), .ALUSrcA(t_srca), .ALUSrcB(t_srcb), .ExtZero(t_extz),
    .ALUControl(t_alu), .PCSrc(t_pcsrc), .PCEn(t_pcen), .illegal_instr(t_ill), .state_dbg(t_st)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op;
    funct = fn;
    zero = z;
  endtask

  task automatic branch(input string tag, input logic [5:0] op, input logic z, input logic exp_en);
    go(op, 6'h00, z);
    tick();
    tick();
    chk({tag, " state"}, st, 4'd8);
    chk({tag, " pcsrc"}, pcsrc, 2'd1);
    chk({tag, " alu"}, alu, 4'b0110);
    chk({tag, " pcen"}, pcen, exp_en);
    tick();
    chk({tag, " back"}, st, 4'd0);
  endtask

  initial begin
    reset = 1'b1;
    go(6'h00, 6'h00, 1'b0);
    tick();
    chk("rst irw", irw, 0);
    chk("rst pcen", pcen, 0);
    chk("rst srcb", srcb, 0);
    tick();
    chk("rst state", st, 4'd0);
    reset = 1'b0;
    #1;
    chk("fetch irw", irw, 1);
    chk("fetch pcen", pcen, 1);
    chk("fetch srcb", srcb, 2'd1);
    chk("fetch alu", alu, 4'b0010);
    // or: FETCH, DECODE, EXEC_R, ALUWB, FETCH
    go(6'h00, 6'h25, 1'b0);
    tick();
    chk("or decode", st, 4'd1);
    chk("or dec pcen", pcen, 0);
    chk("or dec srcb", srcb, 2'd3);
    tick();
    chk("or exec", st, 4'd6);
    chk("or alu", alu, 4'b0001);
    chk("or srca", srca, 1);
    chk("or exec pcen", pcen, 0);
    tick();
    chk("or wb", st, 4'd7);
    chk("or rw", rw, 1);
    chk("or dst", dst, 2'd1);
    chk("or m2r", m2r, 2'd0);
    tick();
    chk("or fetch", st, 4'd0);
    // lw: five cycles
    go(6'h23, 6'h00, 1'b0);
    tick();
    tick();
    chk("lw memadr", st, 4'd2);
    chk("lw srcb", srcb, 2'd2);
    tick();
    chk("lw memrd", st, 4'd3);
    chk("lw iord", iord, 1);
    tick();
    chk("lw memwb", st, 4'd4);
    chk("lw rw", rw, 1);
    chk("lw m2r", m2r, 2'd1);
    chk("lw dst", dst, 2'd0);
    tick();
    chk("lw fetch", st, 4'd0);
    // sw: MemWrite exactly one cycle, no RegWrite
    go(6'h2B, 6'h00, 1'b0);
    mw_cnt = 0;
    rw_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      mw_cnt += int'(mw);
      rw_cnt += int'(rw);
      tick();
    end
    chk("sw mw cycles", mw_cnt, 1);
    chk("sw rw cycles", rw_cnt, 0);
    chk("sw fetch", st, 4'd0);
    branch("beq z1", 6'h04, 1'b1, 1'b1);
    branch("beq z0", 6'h04, 1'b0, 1'b0);
    branch("bne z1", 6'h05, 1'b1, 1'b0);
    branch("bne z0", 6'h05, 1'b0, 1'b1);
    // andi / addi
    go(6'h0C, 6'h00, 1'b0);
    tick();
    tick();
    chk("andi state", st, 4'd9);
    chk("andi extz", extz, 1);
    chk("andi alu", alu, 4'b0000);
    tick();
    chk("andi wb dst", dst, 2'd0);
    chk("andi wb rw", rw, 1);
    tick();
    go(6'h08, 6'h00, 1'b0);
    tick();
    tick();
    chk("addi extz", extz, 0);
    chk("addi alu", alu, 4'b0010);
    tick();
    tick();
    chk("addi fetch", st, 4'd0);
    // jal: default unit executes it, trapping variant treats it as illegal and halts
    go(6'h03, 6'h00, 1'b0);
    tick();
    tick();
    chk("jal state", st, 4'd11);
    chk("jal dst", dst, 2'd2);
    chk("jal m2r", m2r, 2'd2);
    chk("jal rw", rw, 1);
    chk("jal pcen", pcen, 1);
    chk("jal pcsrc", pcsrc, 2'd2);
    chk("trap illegal st", t_st, 4'd12);
    chk("trap illegal flag", t_ill, 1);
    tick();
    chk("jal fetch", st, 4'd0);
    chk("trap halt st", t_st, 4'd13);
    chk("trap halt flag", t_ill, 1);
    chk("trap halt strobes", {t_pcen, t_irw, t_rw, t_mw}, 4'b0000);
    // illegal opcode on the default unit: one flagged cycle, then FETCH
    go(6'h3F, 6'h00, 1'b0);
    tick();
    tick();
    chk("ill op state", st, 4'd12);
    chk("ill op flag", ill, 1);
    tick();
    chk("ill op fetch", st, 4'd0);
    chk("ill op clear", ill, 0);
    go(6'h00, 6'h3F, 1'b0);
    tick();
    tick();
    chk("ill fn exec", st, 4'd6);
    tick();
    chk("ill fn state", st, 4'd12);
    chk("ill fn flag", ill, 1);
    tick();
    chk("ill fn fetch", st, 4'd0);
    chk("trap still halt", t_st, 4'd13);
    chk("trap still strobes", {t_pcen, t_irw, t_rw, t_mw}, 4'b0000);
    // reset during MEMRD aborts lw and releases the halted variant
    go(6'h23, 6'h00, 1'b0);
    tick();
    tick();
    tick();
    chk("abort memrd", st, 4'd3);
    reset = 1'b1;
    #1;
    chk("abort iord", iord, 0);
    chk("abort mw rw", {mw, rw}, 2'b00);
    chk("abort trap ill", t_ill, 0);
    tick();
    chk("abort state", st, 4'd0);
    chk("abort op_q", u_dut.op_q, 6'h00);
    chk("abort trap st", t_st, 4'd0);
    reset = 1'b0;
    #1;
    chk("abort fetch irw", irw, 1);
    go(6'h02, 6'h00, 1'b0);
    tick();
    tick();
    chk("j state", st, 4'd10);
    chk("j pcsrc", pcsrc, 2'd2);
    chk("j pcen", pcen, 1);
    chk("j trap state", t_st, 4'd10);
    tick();
    chk("j fetch", st, 4'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
